opicorv32_pcpi_div: RTL and testbench

Iterative 32-bit divider coprocessor on the picorv32 PCPI bus; it implements RV32M DIV, DIVU, REM and REMU. It sits beside the multiplier PCPI stage. Its pcpi_wr/pcpi_rd/pcpi_wait/pcpi_ready outputs feed the core's internal PCPI result merge, in parallel with the multiplier. It uses one restoring shift-subtract step per cycle, for a fixed latency.

---
 rtl/opicorv32_pcpi_div.sv | 117 +++++++++++
 tb/tb_opicorv32_pcpi_div.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/opicorv32_pcpi_div.sv
// Iterative restoring divider on the picorv32 PCPI bus (RV32M DIV/DIVU/REM/REMU).
// One shift-subtract step per cycle; pcpi_ready follows pcpi_valid after 35 cycles.
module opicorv32_pcpi_div (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    input  logic [31:0] pcpi_rs1,
    input  logic [31:0] pcpi_rs2,
    output logic        pcpi_wr,
    output logic [31:0] pcpi_rd,
    output logic        pcpi_wait,
    output logic        pcpi_ready
);

    logic        instr_div, instr_divu, instr_rem, instr_remu;
    logic        div_d, divu_d, rem_d, remu_d;
    logic        wait_q;
    logic        start;
    logic        running;
    logic        outsign;
    logic        signed_op;
    logic [31:0] rs1_abs, rs2_abs;
    logic [31:0] dividend;
    logic [31:0] quotient;
    logic [31:0] mask;
    logic [62:0] divisor;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        div_d  = 1'b0;
        divu_d = 1'b0;
        rem_d  = 1'b0;
        remu_d = 1'b0;
        if (pcpi_valid && !pcpi_ready &&
            pcpi_insn[6:0] == 7'b0110011 && pcpi_insn[31:25] == 7'b0000001) begin
            case (pcpi_insn[14:12])
                3'b100:  div_d  = 1'b1;
                3'b101:  divu_d = 1'b1;
                3'b110:  rem_d  = 1'b1;
                3'b111:  remu_d = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            instr_div  <= 1'b0;
            instr_divu <= 1'b0;
            instr_rem  <= 1'b0;
            instr_remu <= 1'b0;
            wait_q     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
            instr_div  <= div_d;
            instr_divu <= divu_d;
            instr_rem  <= rem_d;
            instr_remu <= remu_d;
            wait_q     <= pcpi_wait;
        end
    end

    assign pcpi_wait = instr_div | instr_divu | instr_rem | instr_remu;
    assign start     = pcpi_wait & ~wait_q;

    // Signed ops divide magnitudes; the sign is reapplied to the result at finish.
    assign signed_op = instr_div | instr_rem;
    assign rs1_abs   = (signed_op && pcpi_rs1[31]) ? -pcpi_rs1 : pcpi_rs1;
    assign rs2_abs   = (signed_op && pcpi_rs2[31]) ? -pcpi_rs2 : pcpi_rs2;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: datapath registers are reset as well, so pcpi_rd reads 0 straight out of reset.
            running    <= 1'b0;
            pcpi_ready <= 1'b0;
            pcpi_wr    <= 1'b0;
            pcpi_rd    <= '0;
            dividend   <= '0;
            divisor    <= '0;
            quotient   <= '0;
            mask       <= '0;
            outsign    <= 1'b0;
        end else begin
            pcpi_ready <= 1'b0;
            pcpi_wr    <= 1'b0;
            if (start) begin
                running  <= 1'b1;
                dividend <= rs1_abs;
                divisor  <= {rs2_abs, 31'b0};
                quotient <= '0;
                mask     <= 32'h8000_0000;
                outsign  <= (instr_div && (pcpi_rs1[31] != pcpi_rs2[31]) && (pcpi_rs2 != '0)) ||
                            (instr_rem && pcpi_rs1[31]);
            end else if (running && !pcpi_valid) begin
                // Core withdrew the instruction: drop the operation silently.
                running <= 1'b0;
            end else if (running && mask == '0) begin
                running    <= 1'b0;
                pcpi_ready <= 1'b1;
                pcpi_wr    <= 1'b1;
                if (instr_div || instr_divu)
                    pcpi_rd <= outsign ? -quotient : quotient;
                else
                    pcpi_rd <= outsign ? -dividend : dividend;
            end else if (running) begin
                if (divisor <= {31'b0, dividend}) begin
                    dividend <= dividend - divisor[31:0];
                    quotient <= quotient | mask;
                end
                divisor <= divisor >> 1;
                mask    <= mask >> 1;
            end
        end
    end

endmodule

// File: tb/tb_opicorv32_pcpi_div.sv
// Self-checking bench for opicorv32_pcpi_div: scoreboarded ops, latency, abort, reset, non-claim.
module tb_opicorv32_pcpi_div;

    logic        clk        = 1'b0;
    logic        resetn     = 1'b0;
    logic        pcpi_valid = 1'b0;
    logic [31:0] pcpi_insn  = '0;
    logic [31:0] pcpi_rs1   = '0;
    logic [31:0] pcpi_rs2   = '0;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_wait;
    logic        pcpi_ready;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_rd  = '0;

    opicorv32_pcpi_div dut (
        .clk        (clk),
        .resetn     (resetn),
        .pcpi_valid (pcpi_valid),
        .pcpi_insn  (pcpi_insn),
        .pcpi_rs1   (pcpi_rs1),
        .pcpi_rs2   (pcpi_rs2),
        .pcpi_wr    (pcpi_wr),
        .pcpi_rd    (pcpi_rd),
        .pcpi_wait  (pcpi_wait),
        .pcpi_ready (pcpi_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] mk_insn(input logic [2:0] f3, input logic [6:0] opc);
        return {7'b0000001, 5'd2, 5'd1, f3, 5'd1, opc};
    endfunction

    // Reference behaviour written from RV32M semantics, independent of the iterative algorithm.
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'b100:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
            3'b101:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110:  return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Starts at the beginning of cycle 0; returns at the beginning of the cycle after ready.
    task automatic do_op(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string tag);
        int          lat;
        int          wait_low;
        bit          done;
        logic        wr_v;
        logic [31:0] rd_v;
        logic [31:0] exp_v;
        pcpi_insn  = insn;
        pcpi_rs1   = a;
        pcpi_rs2   = b;
        pcpi_valid = 1'b1;
        exp_q.push_back(exp);
        lat = -1; wait_low = 0; done = 1'b0; wr_v = 1'b0; rd_v = '0;
        for (int c = 0; c <= 40 && !done; c++) begin
            @(negedge clk);
            if (c == 0) check({tag, ".ready_idle"}, {31'b0, pcpi_ready}, 32'd0);
            if (c >= 1 && !pcpi_wait) wait_low++;
            if (pcpi_ready) begin
                done = 1'b1;
                lat  = c;
                wr_v = pcpi_wr;
                rd_v = pcpi_rd;
            end
        end
        exp_v = exp_q.pop_front();
        check({tag, ".latency"}, 32'(lat), 32'd35);
        check({tag, ".wr"}, {31'b0, wr_v}, 32'd1);
        check({tag, ".rd"}, rd_v, exp_v);
        check({tag, ".wait_held"}, 32'(wait_low), 32'd0);
        last_rd = exp_v;
        @(posedge clk); #1;
        pcpi_valid = 1'b0;
    endtask

    task automatic watch_quiet(input int cycles, input bit incl_wait, input string tag);
        int hits;
        hits = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (pcpi_ready || pcpi_wr || (incl_wait && pcpi_wait)) hits++;
        end
        check({tag, ".quiet"}, 32'(hits), 32'd0);
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a, b;

        repeat (2) @(negedge clk);
        check("reset.ready", {31'b0, pcpi_ready}, 32'd0);
        check("reset.wr",    {31'b0, pcpi_wr},    32'd0);
        check("reset.wait",  {31'b0, pcpi_wait},  32'd0);
        check("reset.rd",    pcpi_rd,             32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        idle(2);

        do_op(32'h0220D0B3, 32'd100, 32'd7, 32'd14, "divu_100_7");
        idle(2);
        do_op(mk_insn(3'b111, 7'h33), 32'd100, 32'd7, 32'd2, "remu_100_7");
        idle(1);

        do_op(mk_insn(3'b100, 7'h33), 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_m7_2");
        do_op(mk_insn(3'b110, 7'h33), 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_m7_2");
        do_op(mk_insn(3'b100, 7'h33), 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, "div_7_m2");

        do_op(mk_insn(3'b100, 7'h33), 32'd5, 32'd0, 32'hFFFF_FFFF, "div_by_zero");
        do_op(mk_insn(3'b110, 7'h33), 32'd5, 32'd0, 32'd5, "rem_by_zero");
        do_op(mk_insn(3'b100, 7'h33), 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
        do_op(mk_insn(3'b110, 7'h33), 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "rem_ovf");
        idle(2);

        pcpi_insn  = mk_insn(3'b000, 7'h33);
        pcpi_rs1   = 32'd12;
        pcpi_rs2   = 32'd3;
        pcpi_valid = 1'b1;
        watch_quiet(40, 1'b1, "mul_noclaim");
        pcpi_insn  = mk_insn(3'b100, 7'h13);
        watch_quiet(40, 1'b1, "opimm_noclaim");
        pcpi_valid = 1'b0;
        idle(2);

        // Abort: valid dropped in cycle 10 of a DIVU.
        pcpi_insn  = mk_insn(3'b101, 7'h33);
        pcpi_rs1   = 32'd1000;
        pcpi_rs2   = 32'd7;
        pcpi_valid = 1'b1;
        idle(10);
        pcpi_valid = 1'b0;
        watch_quiet(45, 1'b0, "abort");
        check("abort.rd_hold", pcpi_rd, last_rd);
        check("abort.wait_off", {31'b0, pcpi_wait}, 32'd0);
        idle(1);
        do_op(mk_insn(3'b101, 7'h33), 32'd9, 32'd3, 32'd3, "divu_after_abort");
        idle(2);

        // Reset asserted in cycle 20 of a DIV.
        pcpi_insn  = mk_insn(3'b100, 7'h33);
        pcpi_rs1   = 32'd1000;
        pcpi_rs2   = 32'd7;
        pcpi_valid = 1'b1;
        idle(20);
        #2;
        check("midreset.busy_before", {31'b0, pcpi_wait}, 32'd1);
        resetn = 1'b0;
        #1;
        check("midreset.ready", {31'b0, pcpi_ready}, 32'd0);
        check("midreset.wr",    {31'b0, pcpi_wr},    32'd0);
        check("midreset.wait",  {31'b0, pcpi_wait},  32'd0);
        check("midreset.rd",    pcpi_rd,             32'd0);
        pcpi_valid = 1'b0;
        idle(2);
        resetn = 1'b1;
        watch_quiet(45, 1'b1, "post_reset");
        idle(1);

        // Back-to-back: second op's valid rises in cycle 36, ready lands in cycle 71.
        do_op(mk_insn(3'b101, 7'h33), 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, "b2b_divu");
        do_op(mk_insn(3'b111, 7'h33), 32'hFFFF_FFFF, 32'd16, 32'd15, "b2b_remu");
        idle(2);

        for (int i = 0; i < 8; i++) begin
            f3 = 3'($urandom_range(4, 7));
            a  = $urandom;
            case (i % 4)
                0:       b = 32'($urandom_range(1, 255));
                1:       b = $urandom;
                2:       b = -32'($urandom_range(1, 1000));
                default: b = (i == 3) ? 32'd0 : 32'd1;
            endcase
            do_op(mk_insn(f3, 7'h33), a, b, model(f3, a, b), $sformatf("rand%0d", i));
        end

        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
